// File: rtl/double_to_sig_16b.sv
// double_to_sig_16b
// Output stage of the echo-cancellation datapath: converts an IEEE-754
// binary64 sample into a signed 16-bit PCM word using round-half-away-
// from-zero with saturation, in a 2-stage pipeline (1-cycle latency,
// one sample per cycle).
//
// Ports:
//   clk_operation           operation clock, rising edge
//   rst                     synchronous, active-high reset
//   sampling_cycle_counter  position in sampling period (reserved, unused)
//   enable                  accept `double` on this rising edge when 1
//   double                  binary64 input sample
//   sig16b                  registered two's-complement result
module double_to_sig_16b (
  input  logic        clk_operation,
  input  logic        rst,
  input  logic [12:0] sampling_cycle_counter,
  input  logic        enable,
  input  logic [63:0] double,
  output logic [15:0] sig16b
);

  typedef enum logic [1:0] {
    CLS_ZERO  = 2'd0,
    CLS_ROUND = 2'd1,
    CLS_SAT   = 2'd2
  } cls_t;

  logic        sign_in;
  logic [10:0] exp_in;
  logic [51:0] frac_in;

  assign sign_in = double[63];
  assign exp_in  = double[62:52];
  assign frac_in = double[51:0];

  // Reserved input, intentionally ignored.
  logic unused_scc;
  assign unused_scc = ^sampling_cycle_counter;

  // In the rounding range (1022 <= e <= 1037) the significand is shifted
  // right by 1074-e (>= 37), keeping the integer part plus one round bit.
  // The fixed part of that shift is done by taking m[52:37]; the remaining
  // 1037-e (0..15) equals 13-e[3:0] modulo 16 within this range.
  logic [15:0] sig_hi;
  logic [3:0]  rshift;
  cls_t        cls_d;
  logic [15:0] mag_d;

  assign sig_hi = {1'b1, frac_in[51:37]};
  assign rshift = 4'd13 - exp_in[3:0];

  always_comb begin
    cls_d = CLS_ZERO;
    mag_d = '0;
    if (exp_in == 11'h7FF) begin
      cls_d = (frac_in != '0) ? CLS_ZERO : CLS_SAT;
    end else if (exp_in < 11'd1022) begin
      cls_d = CLS_ZERO;
    end else if (exp_in >= 11'd1038) begin
      cls_d = CLS_SAT;
    end else begin
      cls_d = CLS_ROUND;
      mag_d = sig_hi >> rshift;
    end
  end

  // Stage 1 registers
  logic        s1_valid;
  cls_t        s1_cls;
  logic        s1_sign;
  logic [15:0] s1_mag;

  always_ff @(posedge clk_operation) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_cls   <= CLS_ZERO;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
    end else if (enable) begin
      s1_valid <= 1'b1;
      s1_cls   <= cls_d;
      s1_sign  <= sign_in;
      s1_mag   <= mag_d;
    end else begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: round, saturate, negate
  logic [15:0] mag_rnd;
  logic [15:0] result;

  // s1_mag holds {integer[14:0], round_bit}; the sum tops out at 32768.
  assign mag_rnd = {1'b0, s1_mag[15:1]} + {15'd0, s1_mag[0]};

  always_comb begin
    result = '0;
    case (s1_cls)
      CLS_SAT:   result = s1_sign ? 16'h8000 : 16'h7FFF;
      CLS_ROUND: begin
        if (!s1_sign && (mag_rnd > 16'd32767))
          result = 16'h7FFF;
        else if (s1_sign && (mag_rnd > 16'd32768))
          result = 16'h8000;
        else
          result = s1_sign ? (16'd0 - mag_rnd) : mag_rnd;
      end
      default:   result = '0;
    endcase
  end

  always_ff @(posedge clk_operation) begin
    if (rst)
      sig16b <= '0;
    else if (s1_valid)
      sig16b <= result;
  end

endmodule

// File: tb/tb_double_to_sig_16b.sv
module tb_double_to_sig_16b;

  logic        clk_operation;
  logic        rst;
  logic [12:0] sampling_cycle_counter;
  logic        enable;
  logic [63:0] double;
  logic [15:0] sig16b;

  double_to_sig_16b dut (
    .clk_operation          (clk_operation),
    .rst                    (rst),
    .sampling_cycle_counter (sampling_cycle_counter),
    .enable                 (enable),
    .double                 (double),
    .sig16b                 (sig16b)
  );

  initial clk_operation = 1'b0;
  always #5 clk_operation = ~clk_operation;

  typedef struct {
    logic [15:0] exp;
    int          due;
    string       tag;
  } sb_entry_t;

  sb_entry_t sb[$];
  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  task automatic check_now(input string tag, input logic [15:0] exp);
    checks++;
    assert (sig16b === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", tag, sig16b, exp);
      end
  endtask

  // Advance one rising edge, then compare every scoreboard entry due now.
  task automatic tick();
    sb_entry_t e;
    @(posedge clk_operation);
    cyc++;
    #1;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checks++;
      assert (e.due == cyc && sig16b === e.exp)
        else begin
          errors++;
          $error("FAIL %s: observed=%h expected=%h (cycle %0d due %0d)",
                 e.tag, sig16b, e.exp, cyc, e.due);
        end
    end
  endtask

  // Drive inputs for the next edge; when accepted, the result is due
  // after the edge following the sampling edge.
  task automatic drive(input logic en, input logic [63:0] d,
                       input logic push, input logic [15:0] exp,
                       input string tag);
    sb_entry_t e;
    enable = en;
    double = d;
    sampling_cycle_counter = 13'($urandom);
    if (en && push) begin
      e.exp = exp;
      e.due = cyc + 2;
      e.tag = tag;
      sb.push_back(e);
    end
  endtask

  task automatic pulse(input logic [63:0] d, input logic [15:0] exp,
                       input string tag);
    drive(1'b1, d, 1'b1, exp, tag);
    tick();
    drive(1'b0, 64'h0, 1'b0, 16'h0, "");
    tick();
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b1;
    double = 64'h3FF0000000000000;
    sampling_cycle_counter = '0;

    // Reset with enable held high
    tick();
    check_now("reset_c1", 16'h0000);
    tick();
    check_now("reset_c2", 16'h0000);
    rst = 1'b0;
    drive(1'b1, 64'h3FF0000000000000, 1'b1, 16'h0001, "post_reset_1p0");
    tick();
    check_now("reset_plus1", 16'h0000);
    drive(1'b0, 64'h0, 1'b0, 16'h0, "");
    tick();
    tick();

    // Rounding
    pulse(64'h3FF0000000000000, 16'h0001, "round_1p0");
    pulse(64'hC004000000000000, 16'hFFFD, "round_m2p5");
    pulse(64'h3FDF5C28F5C28F5C, 16'h0000, "round_0p49");
    pulse(64'h3FE0000000000000, 16'h0001, "round_0p5");
    pulse(64'h40DFFFE000000000, 16'h7FFF, "round_32767p5");
    pulse(64'hC0DFFFE000000000, 16'h8000, "round_m32767p5");
    pulse(64'h4058FC0000000000, 16'h0064, "round_99p9375");

    // Saturation
    pulse(64'h40E3880000000000, 16'h7FFF, "sat_40000");
    pulse(64'hC0E0000000000000, 16'h8000, "sat_m32768");
    pulse(64'hC12E848000000000, 16'h8000, "sat_m1e6");
    pulse(64'h40DFFFD99999999A, 16'h7FFF, "sat_32767p4");

    // Specials
    pulse(64'h7FF8000000000000, 16'h0000, "nan");
    pulse(64'h7FF0000000000000, 16'h7FFF, "pos_inf");
    pulse(64'hFFF0000000000000, 16'h8000, "neg_inf");
    pulse(64'h8000000000000000, 16'h0000, "neg_zero");
    pulse(64'h0000000000000001, 16'h0000, "subnormal");

    // Streaming
    drive(1'b1, 64'h3FF0000000000000, 1'b1, 16'h0001, "stream_1");
    tick();
    drive(1'b1, 64'h4000000000000000, 1'b1, 16'h0002, "stream_2");
    tick();
    drive(1'b1, 64'h4008000000000000, 1'b1, 16'h0003, "stream_3");
    tick();
    drive(1'b0, 64'h4059000000000000, 1'b0, 16'h0, "");
    tick();
    tick();
    check_now("stream_hold_a", 16'h0003);
    tick();
    check_now("stream_hold_b", 16'h0003);

    // Reset mid-operation: 100.0 must never appear
    drive(1'b1, 64'h4059000000000000, 1'b0, 16'h0, "");
    tick();
    rst = 1'b1;
    drive(1'b0, 64'h0, 1'b0, 16'h0, "");
    tick();
    check_now("midrst_c1", 16'h0000);
    rst = 1'b0;
    tick();
    check_now("midrst_c2", 16'h0000);
    tick();
    check_now("midrst_c3", 16'h0000);

    // Nothing left outstanding in the scoreboard
    checks++;
    assert (sb.size() == 0)
      else begin
        errors++;
        $error("FAIL sb_drain: observed=%0d expected=0 pending", sb.size());
      end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=cycle %0d expected=completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/double_to_sig_16b.md
# double_to_sig_16b

Converts an IEEE-754 double-precision sample into a signed 16-bit PCM word. It is the output stage of the echo-cancellation datapath. It takes either the adaptive-filter error (training phase) or the echo-free signal (cancellation phase) and drives the 16-bit audio output. The conversion uses round-to-nearest with saturation, through a 2-stage pipeline.

## Interface
- No parameters.
- clk_operation  input  1  operation clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous, active-high; clock clk_operation.
- sampling_cycle_counter  input  13  position within the current sampling period. Reserved: it has no functional effect, and the output must not depend on it.
- enable  input  1  level-sensitive; when 1 on a rising edge, `double` is accepted for conversion.
- double  input  64  IEEE-754 binary64 value to convert.
- sig16b  output  16  two's-complement result, registered.

## Operation
- Field decode of `double`:
  - s = double[63]
  - e = double[62:52]
  - f = double[51:0]
- Classification, in priority order:
  - e==2047, f!=0 (NaN): result 0.
  - e==2047, f==0 (±Inf): result +32767 if s=0, −32768 if s=1.
  - e<1022 (|x|<0.5, including ±0 and subnormals): result 0.
  - e>=1038 (|x|>=32768): saturate to +32767 / −32768 by sign.
  - Otherwise: mag = floor(|x| + 0.5), i.e. round half away from zero.
    - Form significand m = {1,f} (53 bits).
    - Shift right by (1075 − e); keep one extra bit as the round bit.
    - Add the round bit.
- Saturation after rounding:
  - Positive: mag > 32767 gives 32767.
  - Negative: mag > 32768 gives −32768.
  - Otherwise result = s ? −mag : mag.
- No exceptions or status flags are produced. Sign of zero is irrelevant: the result is 0.
- Each accepted input produces exactly one output update. Back-to-back inputs (enable held high) are accepted every cycle.

## Timing
- Stage 1, at rising edge N with enable=1:
  - Register the decoded class, sign, and shifted magnitude with the round bit.
  - Set the internal valid flag.
  - With enable=0, the valid flag clears.
- Stage 2, at rising edge N+1 with valid=1: apply rounding, saturation and negation, and load sig16b.
- Latency: an input sampled at edge N is visible on sig16b after edge N+1.
- Throughput: 1 input/cycle.
- When no valid result completes, sig16b holds its last value indefinitely.
- Reset values: sig16b = 16'h0000, internal valid = 0, stage-1 registers = 0.
- rst has priority over enable at the same edge.
- Reset mid-operation: a stage-1 entry in flight is discarded, and no update follows the reset.
- First enable after rst deasserts converts normally, with the same 1-cycle latency.
- Enable deasserted while stage 1 is valid: the in-flight result still completes at the next edge.

## Test plan
- Reset: assert rst for 2 cycles with enable=1 and double = 0x3FF0000000000000 → sig16b = 0x0000 during and 1 cycle after reset. Then release → sig16b = 1 after 2 edges.
- Rounding, enable pulsed 1 cycle each:
  - 0x3FF0000000000000 (1.0) → 1
  - 0xC004000000000000 (−2.5) → −3 (0xFFFD)
  - 0x3FDF5C28F5C28F5C (0.49) → 0
  - 0x3FE0000000000000 (0.5) → 1
- Saturation:
  - 0x40E3880000000000 (40000.0) → 0x7FFF
  - 0xC0E0000000000000 (−32768.0) → 0x8000
  - 0xC12E848000000000 (−1e6) → 0x8000
  - 0x40DFFFD99999999A (32767.4) → 0x7FFF
- Specials:
  - 0x7FF8000000000000 (NaN) → 0
  - 0x7FF0000000000000 (+Inf) → 0x7FFF
  - 0xFFF0000000000000 (−Inf) → 0x8000
  - 0x8000000000000000 (−0) → 0
- Streaming: hold enable=1 and present 1.0, 2.0, 3.0 on consecutive edges → sig16b = 1, 2, 3 on consecutive cycles, each 1 cycle after its input. Then drop enable → sig16b stays 3.
- Reset mid-operation: accept 0x4059000000000000 (100.0) and assert rst on the next edge → sig16b = 0, and 100 never appears.
